// File: rtl/divu_seq_pkg.sv
// Shared definitions for the sequential unsigned divider: ALU function codes and FSM states.
// The function codes match the ones ALUControl emits on its SignaltoDIV output.
package divu_seq_pkg;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_DIVU = 6'b011011;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_OUT  = 6'b111111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2,
        StHold = 2'd3
    } state_t;

endpackage

// File: rtl/divu_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only if it did not go negative.
module divu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] dvd_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           q_bit;
    // The partial remainder is always below the divisor, so its top bit never carries data.
    logic           unused_rem_msb;

    assign unused_rem_msb = rem[WIDTH];

    always_comb begin
        shifted  = {rem[WIDTH-1:0], dvd[WIDTH-1]};
        trial    = shifted - {1'b0, dsr};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial : shifted;
        dvd_next = {dvd[WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/divu_seq.sv
// Sequential WIDTH-bit unsigned divider started by the DIVU function code; one quotient
// bit per clock, results registered for HiLo capture (quotient to LO, remainder to HI).
module divu_seq
    import divu_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter logic [5:0]  FUNCT_DIVU = FN_DIVU,
    parameter logic [5:0]  FUNCT_OUT  = FN_OUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] dvd_next;
    logic             is_divu;
    logic             abort;

    divu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .dvd      (dvd_q),
        .dsr      (dsr_q),
        .rem_next (rem_next),
        .dvd_next (dvd_next)
    );

    assign is_divu = (Signal == FUNCT_DIVU);
    // OUT can never legitimately arrive mid-run, so it is treated like any other abort.
    assign abort   = !is_divu || (Signal == FUNCT_OUT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (is_divu) begin
                    dvd_d   = dividend;
                    dsr_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    rem_d = rem_next;
                    dvd_d = dvd_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                quot_d  = dvd_q;
                remd_d  = rem_q[WIDTH-1:0];
                dbz_d   = (dsr_q == '0);
                done_d  = 1'b1;
                state_d = is_divu ? StHold : StIdle;
            end
            StHold: begin
                // Wait out a long DIVU so the same instruction cannot start a second divide.
                if (!is_divu) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            remd_q  <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dbz_q;
    assign done        = done_q;
    assign busy        = (state_q == StRun);

endmodule
